// File: rtl/count_tracker_pkg.sv
// Shared definitions for the count tracker: state encoding and count-range helpers.
package count_tracker_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 2;
   localparam int unsigned COUNT_MAX = (1 << DEF_WIDTH) - 1;

   function automatic int unsigned count_max(input int unsigned w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/count_tracker_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of rolling over.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] value
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         value <= '0;
      end else if (inc && (value != {W{1'b1}})) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/count_tracker.sv
// Monitor for an enable-gated up-counter: predicts each count, flags wraps and
// latches the first departure from the prediction until cleared.
//
// state | meaning
// SYNC  | load prediction from the live count, no compare
// TRACK | compare count_in against prediction every cycle
// FAULT | mismatch latched, prediction frozen, wait for clear_err
module count_tracker
   import count_tracker_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              clear_err,
   output logic              tracking,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              error,
   output logic [ERR_W-1:0]  error_count,
   output logic [WIDTH-1:0]  bad_value,
   output logic [WIDTH-1:0]  exp_value
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(count_max(WIDTH));

   state_t           state, state_nxt;
   logic [WIDTH-1:0] expected, expected_nxt;
   logic             match;
   logic             wrap_hit;
   logic             fault_hit;

   always_comb begin
      state_nxt    = state;
      expected_nxt = expected;
      wrap_hit     = 1'b0;
      fault_hit    = 1'b0;
      match        = (count_in == expected);
      case (state)
         SYNC: begin
            expected_nxt = count_in + WIDTH'(enable);
            state_nxt    = TRACK;
         end
         TRACK: begin
            if (match) begin
               expected_nxt = expected + WIDTH'(enable);
               wrap_hit     = enable && (count_in == CNT_MAX);
            end else begin
               state_nxt = FAULT;
               fault_hit = 1'b1;
            end
         end
         FAULT: begin
            if (clear_err) state_nxt = SYNC;
         end
         default: state_nxt = SYNC;
      endcase
   end

   // Flags are registered from the next state so they line up with the state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= SYNC;
         expected   <= '0;
         tracking   <= 1'b0;
         error      <= 1'b0;
         wrap_pulse <= 1'b0;
         bad_value  <= '0;
         exp_value  <= '0;
      end else begin
         state      <= state_nxt;
         expected   <= expected_nxt;
         tracking   <= (state_nxt == TRACK);
         error      <= (state_nxt == FAULT);
         wrap_pulse <= wrap_hit;
         if (fault_hit) begin
            bad_value <= count_in;
            exp_value <= expected;
         end
      end
   end

   sat_counter #(.W(WRAP_W)) u_wrap_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wrap_hit),
      .value (wrap_count)
   );

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (fault_hit),
      .value (error_count)
   );

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed vector table, wrap/error saturation sequences
// and a randomized run against a behavioural model of the tracking rules.
module tb_count_tracker;

   localparam int WIDTH = 2;
   localparam int MODV  = 1 << WIDTH;

   logic             clock;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] count_in;
   logic             clear_err;

   logic             tracking, wrap_pulse, error;
   logic [7:0]       wrap_count;
   logic [3:0]       error_count;
   logic [WIDTH-1:0] bad_value, exp_value;

   logic             tracking2, wrap_pulse2, error2;
   logic [1:0]       wrap_count2;
   logic [3:0]       error_count2;
   logic [WIDTH-1:0] bad_value2, exp_value2;

   int n_checks = 0;
   int n_errors = 0;

   count_tracker #(.WIDTH(WIDTH), .WRAP_W(8), .ERR_W(4)) dut (
      .clock(clock), .reset(reset), .enable(enable), .count_in(count_in),
      .clear_err(clear_err), .tracking(tracking), .wrap_pulse(wrap_pulse),
      .wrap_count(wrap_count), .error(error), .error_count(error_count),
      .bad_value(bad_value), .exp_value(exp_value)
   );

   count_tracker #(.WIDTH(WIDTH), .WRAP_W(2), .ERR_W(4)) dut_w2 (
      .clock(clock), .reset(reset), .enable(enable), .count_in(count_in),
      .clear_err(clear_err), .tracking(tracking2), .wrap_pulse(wrap_pulse2),
      .wrap_count(wrap_count2), .error(error2), .error_count(error_count2),
      .bad_value(bad_value2), .exp_value(exp_value2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input int c, input logic cl);
      reset     = r;
      enable    = e;
      count_in  = WIDTH'(c);
      clear_err = cl;
   endtask

   typedef struct {
      logic rst, en;
      int   cnt;
      logic clr;
      logic trk, err, wp;
      int   wc, ec, bad, expv;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst, en, input int cnt, input logic clr,
                               input logic trk, err, wp, input int wc, ec, bad, expv);
      vec_t v;
      v.rst = rst; v.en = en; v.cnt = cnt; v.clr = clr;
      v.trk = trk; v.err = err; v.wp = wp;
      v.wc = wc; v.ec = ec; v.bad = bad; v.expv = expv;
      return v;
   endfunction

   // behavioural model: phase 0=sync, 1=track, 2=fault
   int m_phase, m_pred, m_bad, m_expv, m_errs, m_wraps;
   bit m_trk, m_err, m_wp;

   task automatic model_step(input logic r, input logic e, input int cin, input logic cl);
      m_wp = 0;
      if (!r) begin
         m_phase = 0; m_pred = 0; m_bad = 0; m_expv = 0; m_errs = 0; m_wraps = 0;
      end else if (m_phase == 0) begin
         m_pred  = (cin + int'(e)) % MODV;
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (cin == m_pred) begin
            m_wp = (cin == MODV - 1) && e;
            if (m_wp && m_wraps < 255) m_wraps++;
            m_pred = (m_pred + int'(e)) % MODV;
         end else begin
            m_bad   = cin;
            m_expv  = m_pred;
            m_errs  = (m_errs < 15) ? m_errs + 1 : 15;
            m_phase = 2;
         end
      end else if (cl) begin
         m_phase = 0;
      end
      m_trk = (m_phase == 1);
      m_err = (m_phase == 2);
   endtask

   initial begin
      int wraps;
      int ctr;
      int cin;
      logic r, e, cl;

      drive(1'b0, 1'b0, 0, 1'b0);

      // directed vectors: reset, counting with wraps, fault capture, clear, reset-in-fault
      vq.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0));
      vq.push_back(mk(1,0,0,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,0,0,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,1,0,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,1,1,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,1,2,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,1,3,0, 1,0,1, 1,0,0,0));
      vq.push_back(mk(1,1,0,0, 1,0,0, 1,0,0,0));
      vq.push_back(mk(1,1,1,0, 1,0,0, 1,0,0,0));
      vq.push_back(mk(1,1,2,0, 1,0,0, 1,0,0,0));
      vq.push_back(mk(1,1,3,0, 1,0,1, 2,0,0,0));
      vq.push_back(mk(1,1,0,0, 1,0,0, 2,0,0,0));
      vq.push_back(mk(1,1,2,0, 0,1,0, 2,1,2,1));
      vq.push_back(mk(1,1,3,0, 0,1,0, 2,1,2,1));
      vq.push_back(mk(1,0,0,0, 0,1,0, 2,1,2,1));
      vq.push_back(mk(1,1,3,1, 0,0,0, 2,1,2,1));
      vq.push_back(mk(1,1,3,0, 1,0,0, 2,1,2,1));
      vq.push_back(mk(1,1,0,0, 1,0,0, 2,1,2,1));
      vq.push_back(mk(1,1,1,1, 1,0,0, 2,1,2,1));
      vq.push_back(mk(1,0,3,0, 0,1,0, 2,2,3,2));
      vq.push_back(mk(0,1,1,1, 0,0,0, 0,0,0,0));
      vq.push_back(mk(1,0,0,0, 1,0,0, 0,0,0,0));
      vq.push_back(mk(1,0,1,0, 0,1,0, 0,1,1,0));

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].en, vq[i].cnt, vq[i].clr);
         tick();
         chk($sformatf("v%0d tracking", i),    tracking,    vq[i].trk);
         chk($sformatf("v%0d error", i),       error,       vq[i].err);
         chk($sformatf("v%0d wrap_pulse", i),  wrap_pulse,  vq[i].wp);
         chk($sformatf("v%0d wrap_count", i),  wrap_count,  vq[i].wc);
         chk($sformatf("v%0d error_count", i), error_count, vq[i].ec);
         chk($sformatf("v%0d bad_value", i),   bad_value,   vq[i].bad);
         chk($sformatf("v%0d exp_value", i),   exp_value,   vq[i].expv);
      end

      // five clean wraps: 2-bit wrap counter saturates at 3
      drive(1'b0, 1'b0, 0, 1'b0);
      tick(); tick();
      drive(1'b1, 1'b0, 0, 1'b0);
      tick();
      wraps = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, i % 4, 1'b0);
         tick();
         if (i % 4 == 3) begin
            wraps++;
            chk($sformatf("w2 pulse wrap%0d", wraps), wrap_pulse2, 1);
            chk($sformatf("w2 count wrap%0d", wraps), wrap_count2, (wraps < 3) ? wraps : 3);
         end else begin
            chk($sformatf("w2 pulse idle%0d", i), wrap_pulse2, 0);
         end
      end
      chk("w8 count after 5 wraps", wrap_count, 5);
      chk("w8 no error", error, 0);

      // repeated faults: error_count saturates at 15, fault still latched
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 1'b0, 2, 1'b0);
         tick();
         chk($sformatf("sat%0d error", k), error, 1);
         chk($sformatf("sat%0d error_count", k), error_count, (k < 15) ? k : 15);
         drive(1'b1, 1'b0, 2, 1'b1);
         tick();
         chk($sformatf("sat%0d cleared", k), error, 0);
         drive(1'b1, 1'b0, 0, 1'b0);
         tick();
         chk($sformatf("sat%0d resync", k), tracking, 1);
      end

      // randomized run: ideal counter with occasional corrupted samples
      drive(1'b0, 1'b0, 0, 1'b0);
      model_step(1'b0, 1'b0, 0, 1'b0);
      tick();
      ctr = 0;
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 199) != 0);
         e   = ($urandom_range(0, 3) != 0);
         cl  = ($urandom_range(0, 3) == 0);
         cin = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, MODV - 1)) : ctr;
         drive(r, e, cin, cl);
         model_step(r, e, cin, cl);
         ctr = r ? (ctr + int'(e)) % MODV : 0;
         tick();
         chk("rnd tracking",    tracking,    m_trk);
         chk("rnd error",       error,       m_err);
         chk("rnd wrap_pulse",  wrap_pulse,  m_wp);
         chk("rnd wrap_count",  wrap_count,  m_wraps);
         chk("rnd error_count", error_count, m_errs);
         chk("rnd bad_value",   bad_value,   m_bad);
         chk("rnd exp_value",   exp_value,   m_expv);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/count_tracker.md
Name: count_tracker

Overview:
- Downstream monitor for the free-running enable-gated up-counter. It consumes the counter's count output and the same enable strobe the counter receives.
- Predicts the expected count each cycle, emits a one-cycle wrap pulse and keeps a saturating wrap tally.
- Detects any count that departs from the prediction (skip, stall, spurious reset) and latches it until software-style clear.
- Sits beside the counter in the same clock domain, driven by the same clock, reset and enable.

Parameters:
- WIDTH, 2, count width; must match the counter output width.
- WRAP_W, 8, width of the saturating wrap counter.
- ERR_W, 4, width of the saturating fault counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset. 0 at a rising edge resets the block.
- enable  input  1  the counter's increment enable, sampled at the same edge the counter samples it.
- count_in  input  WIDTH  the counter's registered output.
- clear_err  input  1  acknowledges a fault; acted on only in FAULT.
- tracking  output  1  high while in TRACK.
- wrap_pulse  output  1  one-cycle pulse in the cycle count_in shows the wrapped value 0.
- wrap_count  output  WRAP_W  number of wraps seen; saturates at all-ones.
- error  output  1  high in FAULT.
- error_count  output  ERR_W  faults detected since reset; saturates at all-ones.
- bad_value  output  WIDTH  count_in captured at the fault.
- exp_value  output  WIDTH  prediction captured at the fault.

Behaviour:
- Reset: every output and register is 0, including the internal expected register. State is SYNC.
- States:
  - SYNC: no compare. expected <= count_in + enable (mod 2^WIDTH). Next state is TRACK unconditionally.
  - TRACK: match = (count_in == expected).
    - On match: expected <= expected + enable (mod 2^WIDTH). Stay in TRACK.
    - On mismatch: go to FAULT. Capture bad_value <= count_in and exp_value <= expected. error_count += 1, saturating.
  - FAULT: no compare; expected is frozen. clear_err=1 returns the state to SYNC; otherwise stay in FAULT.
- Registered outputs:
  - tracking = (state == TRACK).
  - error = (state == FAULT).
  - Both update in the cycle after the transition edge.
- Wrap:
  - wrap_pulse <= (state==TRACK && match && count_in==2^WIDTH-1 && enable).
  - wrap_pulse is therefore high exactly in the cycle count_in reads 0 after wrapping.
  - wrap_count increments on the same condition, saturating at 2^WRAP_W-1.
- Latency: a mismatch on count_in at edge N gives error=1 and tracking=0 from edge N onward (registered), i.e. visible one cycle after the bad value appears.
- Boundary conditions:
  - enable=0 in TRACK: expected holds. Any change of count_in is a fault.
  - Mismatch and wrap in the same cycle are mutually exclusive, because wrap requires match.
  - clear_err in SYNC or TRACK is ignored.
  - In FAULT, bad_value, exp_value and error_count hold. They are not cleared by clear_err, only by reset.
  - error_count at saturation: the fault is still latched, but the count does not roll over.
  - Reset mid-operation, in any state, overrides clear_err and enable. The block returns to SYNC with all outputs 0.
  - Arithmetic is modulo 2^WIDTH. The counters use a saturating compare before increment; there is no wrap.

Decomposition:
- Shared package holds:
  - state encoding: SYNC=2'd0, TRACK=2'd1, FAULT=2'd2; 2'd3 is illegal and recovers to SYNC;
  - a localparam for the count maximum, (1<<WIDTH)-1.
- One natural sub-module, sat_counter (parameter W; inputs clock, reset, inc; output value), is instantiated twice, for wrap_count and error_count.

Test Plan (WIDTH=2 unless noted):
- reset=0 for 2 cycles, then 1 with count_in=0 and enable=0 -> all outputs 0 during reset; tracking=1 one cycle after release; error stays 0.
- enable=1 for 9 cycles with count_in following 0,1,2,3,0,1,2,3,0 -> wrap_pulse high in both cycles where count_in=0 after 3; wrap_count=2; error=0.
- In TRACK, expected=1, drive count_in=2 -> next cycle error=1, tracking=0, bad_value=2, exp_value=1, error_count=1; further bad values leave all of these unchanged.
- In FAULT, pulse clear_err=1 with count_in=3 and enable=1 -> SYNC, then TRACK with expected=0; count_in=0 next gives no fault and wrap_pulse=0; error_count still 1.
- WRAP_W=2, drive 5 clean wraps -> wrap_count reads 1,2,3,3,3; wrap_pulse still fires on every wrap.
- In FAULT, assert reset=0 together with clear_err=1 -> next cycle all outputs 0 and state SYNC; after release, tracking is 1 one cycle later.
